// File: rtl/prio_enc_scan_disp.sv
// rtl/prio_enc_scan_disp.sv - priority encoder with registered index feeding a multiplexed hex seven-segment scanner
//
// Purpose:
//   Encodes the highest set bit of a request vector into a registered index
//   and valid flag. The index is then shown in hex on a time-multiplexed,
//   multi-digit seven-segment display.
//
// Parameters:
//   IN_W      request width; OUT_W = $clog2(IN_W), minimum 1
//   DIGITS    display digits; must be >= ceil(OUT_W/4) and >= 1
//   SCAN_DIV  clock cycles each digit stays lit; >= 1
//
// Ports:
//   clk    in   1       rising-edge clock
//   rst_n  in   1       asynchronous reset, active low
//   en     in   1       encoder update enable
//   x      in   IN_W    request vector
//   idx    out  OUT_W   index of the highest set bit of x (registered)
//   valid  out  1       last sampled x was non-zero (registered)
//   seg    out  7       segments, active high, seg[0]=a .. seg[6]=g (registered)
//   an     out  DIGITS  digit select, one-hot active low (registered)
//
// Build option:
//   PRIO_SYNC_EN  when defined, x and en pass through 2-flop synchronisers
//                 ahead of the encoder (adds 2 cycles of x->idx latency).

module prio_enc_scan_disp #(
    parameter  int IN_W     = 8,
    parameter  int DIGITS   = 2,
    parameter  int SCAN_DIV = 1024,
    localparam int OUT_W    = (IN_W > 1) ? $clog2(IN_W) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [IN_W-1:0]   x,
    output logic [OUT_W-1:0]  idx,
    output logic              valid,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // Hex to segments, bit order gfedcba.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    logic [IN_W-1:0]     x_e;
    logic                en_e;

`ifdef PRIO_SYNC_EN
    logic [IN_W-1:0]     x_s1_q, x_s2_q;
    logic                en_s1_q, en_s2_q;

    assign x_e  = x_s2_q;
    assign en_e = en_s2_q;
`else
    assign x_e  = x;
    assign en_e = en;
`endif

    logic [OUT_W-1:0]    idx_q, idx_d;
    logic                valid_q, valid_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic [OUT_W-1:0]    enc_idx;
    logic [4*DIGITS-1:0] idx_ext;
    logic [3:0]          nib;

    always_comb begin
        // Ascending scan so the highest set bit is the last one to assign.
        enc_idx = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (x_e[i]) begin
                enc_idx = OUT_W'(i);
            end
        end

        idx_d   = idx_q;
        valid_d = valid_q;
        if (en_e) begin
            idx_d   = enc_idx;
            valid_d = |x_e;
        end

        if (div_cnt_q == DIV_W'(SCAN_DIV - 1)) begin
            div_cnt_d = '0;
            ptr_d     = (ptr_q == PTR_W'(DIGITS - 1)) ? '0 : ptr_q + 1'b1;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
            ptr_d     = ptr_q;
        end

        // Digits above the index width read as zero.
        idx_ext               = '0;
        idx_ext[OUT_W-1:0]    = idx_q;

        nib  = '0;
        an_d = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (ptr_q == PTR_W'(k)) begin
                nib     = idx_ext[4*k +: 4];
                an_d[k] = 1'b0;
            end
        end

        // With no valid request every digit shows a dash (segment g only).
        seg_d = valid_q ? hex7(nib) : 7'h40;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef PRIO_SYNC_EN
            x_s1_q    <= '0;
            x_s2_q    <= '0;
            en_s1_q   <= 1'b0;
            en_s2_q   <= 1'b0;
`endif
            idx_q     <= '0;
            valid_q   <= 1'b0;
            div_cnt_q <= '0;
            ptr_q     <= '0;
            seg_q     <= 7'h00;
            an_q      <= '1;
        end else begin
`ifdef PRIO_SYNC_EN
            x_s1_q    <= x;
            x_s2_q    <= x_s1_q;
            en_s1_q   <= en;
            en_s2_q   <= en_s1_q;
`endif
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            div_cnt_q <= div_cnt_d;
            ptr_q     <= ptr_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign idx   = idx_q;
    assign valid = valid_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule

// File: tb/tb_prio_enc_scan_disp.sv
// tb/tb_prio_enc_scan_disp.sv - directed self-checking bench for prio_enc_scan_disp

module tb_prio_enc_scan_disp;

`ifdef PRIO_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  x8 = '0;
    logic [31:0] x32 = '0;
    logic [3:0]  x4 = '0;

    logic [2:0]  idx_a;
    logic        valid_a;
    logic [6:0]  seg_a;
    logic [1:0]  an_a;

    logic [2:0]  idx_s;
    logic        valid_s;
    logic [6:0]  seg_s;
    logic [1:0]  an_s;

    logic [4:0]  idx_w;
    logic        valid_w;
    logic [6:0]  seg_w;
    logic [1:0]  an_w;

    logic [1:0]  idx_1;
    logic        valid_1;
    logic [6:0]  seg_1;
    logic [0:0]  an_1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prio_enc_scan_disp dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .x(x8),
        .idx(idx_a), .valid(valid_a), .seg(seg_a), .an(an_a)
    );

    prio_enc_scan_disp #(.IN_W(8), .DIGITS(2), .SCAN_DIV(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .x(x8),
        .idx(idx_s), .valid(valid_s), .seg(seg_s), .an(an_s)
    );

    prio_enc_scan_disp #(.IN_W(32), .DIGITS(2), .SCAN_DIV(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .x(x32),
        .idx(idx_w), .valid(valid_w), .seg(seg_w), .an(an_w)
    );

    prio_enc_scan_disp #(.IN_W(4), .DIGITS(1), .SCAN_DIV(1)) dut_1 (
        .clk(clk), .rst_n(rst_n), .en(en), .x(x4),
        .idx(idx_1), .valid(valid_1), .seg(seg_1), .an(an_1)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        x8 = 8'hFF;
        en = 1'b1;
        tick(3);
        checks++; if (idx_a !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", idx_a); end
        checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
        checks++; if (seg_a !== 7'h00) begin failures++; $display("FAIL reset_seg got=%h exp=00", seg_a); end
        checks++; if (an_a !== 2'b11) begin failures++; $display("FAIL reset_an got=%b exp=11", an_a); end
        rst_n = 1'b1;
        tick(1);
        checks++; if (an_a !== 2'b10) begin failures++; $display("FAIL reset_first_an got=%b exp=10", an_a); end
        checks++; if (an_1 !== 1'b0) begin failures++; $display("FAIL reset_first_an_1dig got=%b exp=0", an_1); end
    endtask

    task automatic test_priority();
        x8 = 8'h00;
        tick(LAT + 1);
        checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL prio_clear_valid got=%b exp=0", valid_a); end
        x8 = 8'h81;
        if (LAT > 1) tick(LAT - 1);
        checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL prio_early got=%b exp=0", valid_a); end
        tick(1);
        checks++; if (idx_a !== 3'd7) begin failures++; $display("FAIL prio_81_idx got=%0d exp=7", idx_a); end
        checks++; if (valid_a !== 1'b1) begin failures++; $display("FAIL prio_81_valid got=%b exp=1", valid_a); end
        x8 = 8'h06;
        tick(LAT);
        checks++; if (idx_a !== 3'd2) begin failures++; $display("FAIL prio_06_idx got=%0d exp=2", idx_a); end
        x8 = 8'h00;
        tick(LAT);
        checks++; if (idx_a !== 3'd0) begin failures++; $display("FAIL prio_00_idx got=%0d exp=0", idx_a); end
        checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL prio_00_valid got=%b exp=0", valid_a); end
        tick(1);
        checks++; if (seg_a !== 7'h40) begin failures++; $display("FAIL prio_00_seg_a got=%h exp=40", seg_a); end
        begin
            bit seen0 = 1'b0;
            bit seen1 = 1'b0;
            int bad = 0;
            for (int i = 0; i < 8; i++) begin
                if (seg_s !== 7'h40) bad++;
                if (an_s === 2'b10) seen0 = 1'b1;
                if (an_s === 2'b01) seen1 = 1'b1;
                tick(1);
            end
            checks++; if (bad != 0) begin failures++; $display("FAIL prio_dash_all_digits got=%0d_bad_cycles exp=0", bad); end
            checks++; if (!(seen0 && seen1)) begin failures++; $display("FAIL prio_dash_scanned got=%b%b exp=11", seen1, seen0); end
        end
    endtask

    task automatic test_hold();
        int bad = 0;
        x8 = 8'h20;
        tick(LAT);
        checks++; if (idx_a !== 3'd5 || valid_a !== 1'b1) begin failures++; $display("FAIL hold_load got=%0d/%b exp=5/1", idx_a, valid_a); end
        en = 1'b0;
        x8 = 8'h01;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (idx_a !== 3'd5 || valid_a !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL hold_idx_valid got=%0d_bad_cycles exp=0 (last %0d/%b)", bad, idx_a, valid_a); end
        en = 1'b1;
        tick(LAT);
    endtask

    task automatic test_back_to_back();
        logic [7:0] vec [6] = '{8'h01, 8'h02, 8'h04, 8'h80, 8'h10, 8'h00};
        logic [2:0] exp_i [6] = '{3'd0, 3'd1, 3'd2, 3'd7, 3'd4, 3'd0};
        logic       exp_v [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int bad = 0;
        for (int j = 0; j < 6 + LAT - 1; j++) begin
            x8 = vec[(j < 6) ? j : 5];
            tick(1);
            if (j >= LAT - 1) begin
                if (idx_a !== exp_i[j - LAT + 1] || valid_a !== exp_v[j - LAT + 1]) bad++;
            end
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL back_to_back got=%0d_bad_cycles exp=0", bad); end
    endtask

    task automatic test_scan();
        int bad_an = 0;
        int bad_seg = 0;
        int bad_1 = 0;
        @(negedge clk);
        rst_n = 1'b0;
        x8 = 8'h08;
        x32 = 32'h8000_0000;
        x4 = 4'b0100;
        en = 1'b1;
        tick(1);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            logic [1:0] ea;
            tick(1);
            ea = (((k - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01;
            if (an_s !== ea || an_w !== ea) bad_an++;
            if (an_1 !== 1'b0) bad_1++;
            if (k >= 5) begin
                if (seg_s !== ((ea == 2'b10) ? 7'h4F : 7'h3F)) bad_seg++;
                if (seg_w !== ((ea == 2'b10) ? 7'h71 : 7'h06)) bad_seg++;
                if (seg_1 !== 7'h5B) bad_1++;
            end
        end
        checks++; if (bad_an != 0) begin failures++; $display("FAIL scan_an got=%0d_bad exp=0 (an_s=%b an_w=%b)", bad_an, an_s, an_w); end
        checks++; if (bad_seg != 0) begin failures++; $display("FAIL scan_seg got=%0d_bad exp=0 (seg_s=%h seg_w=%h)", bad_seg, seg_s, seg_w); end
        checks++; if (idx_w !== 5'd31) begin failures++; $display("FAIL wide_idx got=%0d exp=31", idx_w); end
        checks++; if (bad_1 != 0) begin failures++; $display("FAIL one_digit got=%0d_bad exp=0 (seg=%h an=%b)", bad_1, seg_1, an_1); end
    endtask

    task automatic test_async_reset();
        int bad = 0;
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (idx_s !== 3'd0 || valid_s !== 1'b0) begin failures++; $display("FAIL async_idx_valid got=%0d/%b exp=0/0", idx_s, valid_s); end
        checks++; if (seg_s !== 7'h00 || an_s !== 2'b11) begin failures++; $display("FAIL async_seg_an got=%h/%b exp=00/11", seg_s, an_s); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            if (an_s !== ((k <= 4) ? 2'b10 : 2'b01)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL async_restart_dwell got=%0d_bad exp=0", bad); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_hold();
        test_back_to_back();
        test_scan();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
